// File: rtl/datapath_registradores_pkg.sv
// Operation codes shared by the datapath registers, the ULA and the control FSM.
package datapath_registradores_pkg;

   typedef enum logic [2:0] {
      HOLD   = 3'b000,
      LOAD   = 3'b001,
      SHIFTR = 3'b010,
      SHIFTL = 3'b011,
      RESET  = 3'b100
   } reg_op_t;

   typedef enum logic [2:0] {
      ADD   = 3'b000,
      SUB   = 3'b001,
      MAIOR = 3'b010,
      MENOR = 3'b011,
      IGUAL = 3'b100,
      XOR   = 3'b101,
      AND   = 3'b110
   } ula_op_t;

   // Only bits[2:0] select an operation; any code with bit3 set is inert.
   function automatic logic codigo_valido(input logic [3:0] codigo);
      return ~codigo[3];
   endfunction

endpackage

// File: rtl/registrador_n.sv
// N-bit register with hold/load/logical shift/clear operations selected by op.
module registrador_n
   import datapath_registradores_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [3:0]   op,
   input  logic [N-1:0] d,
   output logic [N-1:0] q
);

   always_ff @(posedge clock) begin
      if (reset) begin
         q <= '0;
      end else if (codigo_valido(op)) begin
         case (op[2:0])
            LOAD:    q <= d;
            SHIFTR:  q <= {1'b0, q[N-1:1]};
            SHIFTL:  q <= {q[N-2:0], 1'b0};
            RESET:   q <= '0;
            default: q <= q;
         endcase
      end
   end

endmodule

// File: rtl/datapath_registradores.sv
// Datapath with registers X, Y, Z and a combinational ULA driven by the control FSM codes.
module datapath_registradores
   import datapath_registradores_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [N-1:0] entrada,
   input  logic [3:0]   Tx,
   input  logic [3:0]   Ty,
   input  logic [3:0]   Tz,
   input  logic [3:0]   Tula,
   output logic [N-1:0] X,
   output logic [N-1:0] Y,
   output logic [N-1:0] Z,
   output logic [N-1:0] ula_out,
   output logic         carry,
   output logic         zero
);

   logic         ula_carry;
   logic [N:0]   soma;
   logic         y_carrega;

   registrador_n #(.N(N)) u_reg_x (
      .clock(clock), .reset(reset), .op(Tx), .d(entrada), .q(X)
   );

   registrador_n #(.N(N)) u_reg_y (
      .clock(clock), .reset(reset), .op(Ty), .d(ula_out), .q(Y)
   );

   registrador_n #(.N(N)) u_reg_z (
      .clock(clock), .reset(reset), .op(Tz), .d(Y), .q(Z)
   );

   always_comb begin
      ula_out   = '0;
      ula_carry = 1'b0;
      soma      = '0;
      if (codigo_valido(Tula)) begin
         case (Tula[2:0])
            ADD: begin
               soma      = {1'b0, X} + {1'b0, Y};
               ula_out   = soma[N-1:0];
               ula_carry = soma[N];
            end
            SUB: begin
               ula_out   = X - Y;
               ula_carry = (X < Y);
            end
            MAIOR:   ula_out = {{(N-1){1'b0}}, (X > Y)};
            MENOR:   ula_out = {{(N-1){1'b0}}, (X < Y)};
            IGUAL:   ula_out = {{(N-1){1'b0}}, (X == Y)};
            XOR:     ula_out = X ^ Y;
            AND:     ula_out = X & Y;
            default: ula_out = '0;
         endcase
      end
   end

   assign y_carrega = codigo_valido(Ty) && (Ty[2:0] == LOAD);

   // Flags describe the value most recently loaded into Y, so they only move with a Y LOAD.
   always_ff @(posedge clock) begin
      if (reset) begin
         carry <= 1'b0;
         zero  <= 1'b0;
      end else if (y_carrega) begin
         carry <= ula_carry;
         zero  <= (ula_out == '0);
      end
   end

endmodule
